ltm_video_out: RTL

Parametrised clocked-video output for the LTM panel path. It takes the renderer's pixel stream as an Avalon-ST sink with start/end-of-packet framing and buffers it in an internal FIFO. It generates programmable horizontal and vertical timing and drives the panel's data, valid, sync and blanking signals. It locks to frame boundaries, reports underflow, and resynchronises on its own after underflow or framing errors.

---
 rtl/ltm_video_out.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/ltm_video_out.sv
// Clocked-video output for the LTM panel: buffers an Avalon-ST pixel stream,
// generates programmable H/V timing and locks the stream to frame boundaries.
module ltm_video_out #(
    parameter int DATA_W       = 24,
    parameter int H_ACTIVE     = 800,
    parameter int H_FP         = 40,
    parameter int H_SYNC       = 128,
    parameter int H_BP         = 88,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 13,
    parameter int V_SYNC       = 3,
    parameter int V_BP         = 29,
    parameter int FIFO_DEPTH   = 16,
    parameter int SYNC_ACT_LOW = 1
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              enable,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sop,
    input  logic              in_eop,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_datavalid,
    output logic              vid_h_sync,
    output logic              vid_v_sync,
    output logic              vid_f,
    output logic              vid_h,
    output logic              vid_v,
    output logic              underflow,
    output logic              locked
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int FW      = DATA_W + 2;

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [AW:0]   FULL_CNT   = (AW+1)'(FIFO_DEPTH);
    localparam logic          SYNC_IDLE  = (SYNC_ACT_LOW != 0);

    typedef enum logic [1:0] {ST_DISABLED, ST_WAIT_SOP, ST_RUN} state_t;

    state_t            state_q, state_d;
    logic [HW-1:0]     h_cnt_q, h_cnt_d;
    logic [VW-1:0]     v_cnt_q, v_cnt_d;
    logic [FW-1:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              in_ready_q, in_ready_d;
    logic              stop_q, stop_d, bad_q, bad_d;
    logic              uf_evt_q, uf_evt_d, underflow_q, underflow_d;
    logic [DATA_W-1:0] vid_data_q, vid_data_d;
    logic              vid_dv_q, vid_dv_d, vid_hs_q, vid_hs_d, vid_vs_q, vid_vs_d;
    logic              vid_h_q, vid_h_d, vid_v_q, vid_v_d;

    logic [FW-1:0]     head;
    logic              head_sop, head_eop, fifo_empty, push, pop, flush;
    logic              h_wrap, frame_end, active, at_origin, last_px, idle, hs_act, vs_act;

    // Pixel word layout in the FIFO: {sop, eop, data}.
    always_ff @(posedge clk_clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_sop, in_eop, in_data};
    end

    always_comb begin
        head       = mem_q[rd_ptr_q];
        head_sop   = head[DATA_W+1];
        head_eop   = head[DATA_W];
        fifo_empty = (count_q == '0);
        push       = in_valid && in_ready_q;
        h_wrap     = (h_cnt_q == H_LAST);
        frame_end  = h_wrap && (v_cnt_q == V_LAST);
        active     = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        at_origin  = (h_cnt_q == '0) && (v_cnt_q == '0);
        last_px    = (h_cnt_q == H_ACT_LAST) && (v_cnt_q == V_ACT_LAST);
        idle       = (state_q == ST_DISABLED);
        hs_act     = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
        vs_act     = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);

        state_d    = state_q;
        stop_d     = stop_q;
        bad_d      = bad_q;
        uf_evt_d   = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
        vid_data_d = '0;

        case (state_q)
            ST_DISABLED: begin
                if (enable) state_d = ST_WAIT_SOP;
            end
            ST_WAIT_SOP: begin
                pop = !fifo_empty && !head_sop;
                if (frame_end && !fifo_empty && head_sop) state_d = ST_RUN;
            end
            ST_RUN: begin
                // After a framing error the rest of the frame is left in the
                // FIFO; WAIT_SOP discards it while hunting for the next sop.
                if (active && !stop_q) begin
                    if (fifo_empty) begin
                        uf_evt_d = 1'b1;
                        bad_d    = 1'b1;
                    end else begin
                        pop        = 1'b1;
                        vid_data_d = head[DATA_W-1:0];
                        if ((at_origin && !head_sop) || (head_eop != last_px)) begin
                            uf_evt_d = 1'b1;
                            bad_d    = 1'b1;
                            stop_d   = 1'b1;
                        end
                    end
                end
                if (frame_end) begin
                    stop_d  = 1'b0;
                    bad_d   = 1'b0;
                    state_d = (bad_q || uf_evt_d) ? ST_WAIT_SOP : ST_RUN;
                end
            end
            default: state_d = ST_DISABLED;
        endcase

        if (frame_end && !enable && !idle) begin
            state_d = ST_DISABLED;
            flush   = 1'b1;
            pop     = 1'b0;
        end

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop) count_d = count_q + 1'b1;
        if (pop && !push) count_d = count_q - 1'b1;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
        in_ready_d = (count_d != FULL_CNT);

        h_cnt_d = '0;
        v_cnt_d = '0;
        if (!idle) begin
            h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
            v_cnt_d = v_cnt_q;
            if (h_wrap) v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end

        // Entering or staying in RUN at a frame boundary means the last frame was clean.
        underflow_d = underflow_q || uf_evt_q;
        if (frame_end && state_d == ST_RUN) underflow_d = 1'b0;

        vid_dv_d = !idle && active;
        vid_h_d  = idle || (h_cnt_q >= H_ACT);
        vid_v_d  = idle || (v_cnt_q >= V_ACT);
        vid_hs_d = (!idle && hs_act) ? !SYNC_IDLE : SYNC_IDLE;
        vid_vs_d = (!idle && vs_act) ? !SYNC_IDLE : SYNC_IDLE;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= ST_DISABLED;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            stop_q      <= 1'b0;
            bad_q       <= 1'b0;
            uf_evt_q    <= 1'b0;
            underflow_q <= 1'b0;
            vid_data_q  <= '0;
            vid_dv_q    <= 1'b0;
            vid_hs_q    <= SYNC_IDLE;
            vid_vs_q    <= SYNC_IDLE;
            vid_h_q     <= 1'b1;
            vid_v_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            stop_q      <= stop_d;
            bad_q       <= bad_d;
            uf_evt_q    <= uf_evt_d;
            underflow_q <= underflow_d;
            vid_data_q  <= vid_data_d;
            vid_dv_q    <= vid_dv_d;
            vid_hs_q    <= vid_hs_d;
            vid_vs_q    <= vid_vs_d;
            vid_h_q     <= vid_h_d;
            vid_v_q     <= vid_v_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign vid_data      = vid_data_q;
    assign vid_datavalid = vid_dv_q;
    assign vid_h_sync    = vid_hs_q;
    assign vid_v_sync    = vid_vs_q;
    assign vid_f         = 1'b0;
    assign vid_h         = vid_h_q;
    assign vid_v         = vid_v_q;
    assign underflow     = underflow_q;
    assign locked        = (state_q == ST_RUN);

endmodule
